weight_tile_masker: RTL and testbench
=====================================

// Module: weight_tile_masker
// PURPOSE
// - Streaming mask stage between weight DMA read and the weight FIFO of the conv PE array.
// - Counts one Tn x Tm x K x K weight tile; zeroes any element whose output channel (m) or
//   input channel (n) falls past the layer edge.
// - Successor to the fixed-bound filter:
//   - runtime layer bounds and per-tile start;
//   - valid/ready backpressure;
//   - tile_done pulse;
//   - optional masked-element statistics.
// PARAMETERS
// - CW   16  counter / coordinate width
// - DW   32  weight word width
// - K     3  kernel size; both inner loops run 0..K-1
// - Tm   16  output-channel tile depth
// - Tn   16  input-channel tile depth
// PORTS
// - clk           in   1   clock, all logic rising edge
// - rst           in   1   synchronous, active-high reset
// - start         in   1   1-cycle pulse; latches tile_base_m/n, m_total, n_total
// - tile_base_m   in   CW  first output channel of this tile
// - tile_base_n   in   CW  first input channel of this tile
// - m_total       in   CW  layer output channels (M); legal m < m_total
// - n_total       in   CW  layer input channels (N); legal n < n_total
// - in_valid      in   1   input word valid
// - in_data       in   DW  raw weight word
// - in_ready      out  1   stage accepts a word
// - out_valid     out  1   output word valid
// - out_data      out  DW  weight word, or 0 when masked
// - out_ready     in   1   downstream accepts
// - busy          out  1   tile in progress (RUN or DRAIN)
// - tile_done     out  1   1-cycle pulse when the last tile word leaves the stage
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; all counters 0; latched bounds 0.
// - FSM IDLE -> RUN: on start. start is ignored outside IDLE.
// - FSM RUN -> DRAIN: on acceptance of element Tn*Tm*K*K-1.
// - FSM DRAIN -> IDLE: when that word is handshaken out. tile_done=1 in the same cycle.
// - Counter order: kx (innermost, 0..K-1), ky, tm (0..Tm-1), tn (outermost).
//   - Advances only on in_valid && in_ready; wraps to 0 at the tile end.
// - Legality: (base_m + tm) < m_total && (base_n + tn) < n_total.
//   - Sums computed in CW+1 bits; no wrap-around aliasing.
//   - Evaluated with the counter values of the accepted word.
// - Datapath: one output register, 1-cycle latency.
//   - in_ready = (state==RUN) && (!out_valid || out_ready).
//   - On accept: out_data <= legal ? in_data : 0; out_valid <= 1.
//   - Else, on out_ready: out_valid <= 0.
// - Output holds stable while out_valid && !out_ready.
// - Full throughput, one word per cycle, with no backpressure.
// - Simultaneous out handshake and new accept: register reloads, out_valid stays 1.
// - m_total==0 or n_total==0: every word is masked, but all Tn*Tm*K*K words are still consumed.
// - tile_base >= total: the whole tile is zeroed.
// - Latched bounds remain constant from start to tile_done; input-port changes are ignored.
// - rst mid-tile: FSM, counters and output register clear in the next cycle; any in-flight word is dropped.
// - in_valid while IDLE/DRAIN: not accepted (in_ready=0); no counter change.
// CONFIGURATION
// - Macro WEIGHT_MASK_STATS_EN defined: adds outputs masked_cnt [CW-1:0] and tile_clean [1].
//   - masked_cnt counts words zeroed in the current tile; it clears on start and saturates at all-ones.
//   - tile_clean = (masked_cnt==0), valid in the tile_done cycle.
// - Macro undefined: the ports and their logic are absent; the core behaviour is identical.
// TESTING
// - Interior tile: K=3, Tm=Tn=4, M=N=32, base 0/0, 144 words ramp 1..144 with out_ready=1.
//   -> out == in, tile_done at word 144 + 1 cycle, 144 consecutive valids.
// - Edge tile: M=6, N=5, base_m=4, base_n=4.
//   -> only tm<2 && tn<1 pass (18 words nonzero); the other 126 are 0.
//   -> masked_cnt=126 with STATS_EN.
// - Backpressure: random out_ready at 50%.
//   -> no word lost or duplicated; out_data stable while stalled; sequence matches the model.
// - start during RUN, with different bases -> ignored; the mask follows the original bases.
// - Reset at word 50 of 144 -> all outputs 0 next cycle; a new start runs a full clean tile.
// - Overflow: CW=8, base_m=250, m_total=255, Tm=16.
//   -> tm 0..4 legal, tm 5..15 masked; no wrap-around false pass.

Source files
------------

// File: rtl/weight_tile_masker_if.sv
// Stream bundle around the weight masker: raw words in, masked words out.
// master = upstream DMA plus downstream FIFO side, slave = the masker itself.
interface weight_tile_masker_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/weight_tile_masker.sv
// Streams one TN x TM x K x K weight tile and zeroes words past the layer channel edges.
// Optional masked-word statistics (masked_cnt, tile_clean) under `WEIGHT_MASK_STATS_EN.
module weight_tile_masker #(
  parameter int CW = 16,
  parameter int DW = 32,
  parameter int K  = 3,
  parameter int TM = 16,
  parameter int TN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        tile_base_m,
  input  logic [CW-1:0]        tile_base_n,
  input  logic [CW-1:0]        m_total,
  input  logic [CW-1:0]        n_total,
  weight_tile_masker_if.slave  bus,
  output logic                 busy,
  output logic                 tile_done,
  output logic [1:0]           dbg_state
`ifdef WEIGHT_MASK_STATS_EN
  ,
  output logic [CW-1:0]        masked_cnt,
  output logic                 tile_clean
`endif
);

  localparam int KW  = (K  > 1) ? $clog2(K)  : 1;
  localparam int TMW = (TM > 1) ? $clog2(TM) : 1;
  localparam int TNW = (TN > 1) ? $clog2(TN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic [TMW-1:0] tm_q, tm_d;
  logic [TNW-1:0] tn_q, tn_d;
  logic [CW-1:0]  base_m_q, base_m_d, base_n_q, base_n_d;
  logic [CW-1:0]  m_total_q, m_total_d, n_total_q, n_total_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]  masked_cnt_q, masked_cnt_d;

  logic           in_ready;
  logic           accept;
  logic           out_hs;
  logic           last_elem;
  logic           legal;
  logic [CW:0]    sum_m, sum_n;

  // Handshake: a word moves on a side when valid && ready are both high at the
  // rising edge; valid never waits on ready, and out_data holds while stalled.
  always_comb begin
    state_d      = state_q;
    kx_d         = kx_q;
    ky_d         = ky_q;
    tm_d         = tm_q;
    tn_d         = tn_q;
    base_m_d     = base_m_q;
    base_n_d     = base_n_q;
    m_total_d    = m_total_q;
    n_total_d    = n_total_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    masked_cnt_d = masked_cnt_q;

    in_ready  = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    accept    = bus.in_valid && in_ready;
    out_hs    = out_valid_q && bus.out_ready;
    tile_done = (state_q == DRAIN) && out_hs;
    last_elem = (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1)) &&
                (tm_q == TMW'(TM - 1)) && (tn_q == TNW'(TN - 1));

    // One extra bit keeps base + offset from wrapping back under the total.
    sum_m = {1'b0, base_m_q} + (CW + 1)'(tm_q);
    sum_n = {1'b0, base_n_q} + (CW + 1)'(tn_q);
    legal = (sum_m < {1'b0, m_total_q}) && (sum_n < {1'b0, n_total_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          base_m_d     = tile_base_m;
          base_n_d     = tile_base_n;
          m_total_d    = m_total;
          n_total_d    = n_total;
          masked_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept && last_elem) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // kx innermost, then ky, tm, tn; all wrap to zero on the last element.
    if (accept) begin
      if (kx_q == KW'(K - 1)) begin
        kx_d = '0;
        if (ky_q == KW'(K - 1)) begin
          ky_d = '0;
          if (tm_q == TMW'(TM - 1)) begin
            tm_d = '0;
            if (tn_q == TNW'(TN - 1)) tn_d = '0;
            else                      tn_d = tn_q + 1'b1;
          end else begin
            tm_d = tm_q + 1'b1;
          end
        end else begin
          ky_d = ky_q + 1'b1;
        end
      end else begin
        kx_d = kx_q + 1'b1;
      end
    end

    if (accept) begin
      out_data_d  = legal ? bus.in_data : '0;
      out_valid_d = 1'b1;
      if (!legal && (masked_cnt_q != '1)) masked_cnt_d = masked_cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      kx_q         <= '0;
      ky_q         <= '0;
      tm_q         <= '0;
      tn_q         <= '0;
      base_m_q     <= '0;
      base_n_q     <= '0;
      m_total_q    <= '0;
      n_total_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      masked_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      tm_q         <= tm_d;
      tn_q         <= tn_d;
      base_m_q     <= base_m_d;
      base_n_q     <= base_n_d;
      m_total_q    <= m_total_d;
      n_total_q    <= n_total_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      masked_cnt_q <= masked_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

`ifdef WEIGHT_MASK_STATS_EN
  assign masked_cnt = masked_cnt_q;
  assign tile_clean = tile_done && (masked_cnt_q == '0);
`endif

endmodule

// File: tb/tb_weight_tile_masker.sv
// Bench for weight_tile_masker: two instances (wide/shallow and narrow/deep) share one
// input stream; expected words are queued at acceptance and checked at the output.
module tb_weight_tile_masker;
  localparam int DW = 32, K = 3, WORDS = 144, PERIOD = 10;
  localparam int CWA = 16, TMA = 4,  TNA = 4;
  localparam int CWB = 8,  TMB = 16, TNB = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #(PERIOD / 2) clk = ~clk;

  logic           start, in_valid, out_ready;
  logic [DW-1:0]  in_data;
  logic [CWA-1:0] base_m_a, base_n_a, m_tot_a, n_tot_a;
  logic [CWB-1:0] base_m_b, base_n_b, m_tot_b, n_tot_b;
  logic           busy_a, done_a, busy_b, done_b;
  logic [1:0]     dbg_a, dbg_b;
`ifdef WEIGHT_MASK_STATS_EN
  logic [CWA-1:0] mcnt_a;
  logic [CWB-1:0] mcnt_b;
  logic           clean_a, clean_b;
  int             st_cnt_a, st_cnt_b, st_clean_a, st_clean_b;
`endif

  weight_tile_masker_if #(.DW(DW)) ifa ();
  weight_tile_masker_if #(.DW(DW)) ifb ();
  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  weight_tile_masker #(.CW(CWA), .DW(DW), .K(K), .TM(TMA), .TN(TNA)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .tile_base_m(base_m_a), .tile_base_n(base_n_a), .m_total(m_tot_a), .n_total(n_tot_a),
    .bus(ifa), .busy(busy_a), .tile_done(done_a), .dbg_state(dbg_a)
`ifdef WEIGHT_MASK_STATS_EN
    , .masked_cnt(mcnt_a), .tile_clean(clean_a)
`endif
  );

  weight_tile_masker #(.CW(CWB), .DW(DW), .K(K), .TM(TMB), .TN(TNB)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .tile_base_m(base_m_b), .tile_base_n(base_n_b), .m_total(m_tot_b), .n_total(n_tot_b),
    .bus(ifb), .busy(busy_b), .tile_done(done_b), .dbg_state(dbg_b)
`ifdef WEIGHT_MASK_STATS_EN
    , .masked_cnt(mcnt_b), .tile_clean(clean_b)
`endif
  );

  // scoreboard state
  logic [DW-1:0] exp_qa[$], exp_qb[$];
  int checks = 0, errors = 0;
  int mbm_a, mbn_a, mmt_a, mnt_a, mbm_b, mbn_b, mmt_b, mnt_b;
  int idx_a, idx_b, nz_a, nz_b, vcnt_a, vcnt_b, dcnt_a, dcnt_b;
  bit done_seen_a, done_seen_b, bp_mode = 1'b0;
  bit hold_va, hold_vb;
  logic [DW-1:0] hold_da, hold_db;
  time first_acc_t, done_t_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input int idx, input int tm_depth, input int bm,
                                          input int bn, input int mt, input int nt,
                                          input logic [DW-1:0] d);
    int tm, tn;
    tm = (idx / (K * K)) % tm_depth;
    tn = idx / (K * K * tm_depth);
    return ((bm + tm) < mt && (bn + tn) < nt) ? d : '0;
  endfunction

  // monitor: pops and compares on every output handshake
  always @(negedge clk) begin
    if (rst) begin
      hold_va = 1'b0;
      hold_vb = 1'b0;
    end else begin
      if (hold_va && ifa.out_valid) check("stall_stable_a", ifa.out_data, hold_da);
      if (hold_vb && ifb.out_valid) check("stall_stable_b", ifb.out_data, hold_db);
      if (ifa.out_valid) vcnt_a++;
      if (ifb.out_valid) vcnt_b++;
      if (ifa.out_valid && ifa.out_ready) begin
        if (exp_qa.size() == 0) check("unexpected_out_a", 64'(ifa.out_data), 64'hDEAD);
        else begin
          check("out_data_a", ifa.out_data, exp_qa.pop_front());
          if (ifa.out_data != '0) nz_a++;
        end
      end
      if (ifb.out_valid && ifb.out_ready) begin
        if (exp_qb.size() == 0) check("unexpected_out_b", 64'(ifb.out_data), 64'hDEAD);
        else begin
          check("out_data_b", ifb.out_data, exp_qb.pop_front());
          if (ifb.out_data != '0) nz_b++;
        end
      end
      if (done_a) begin
        dcnt_a++; done_seen_a = 1'b1; done_t_a = $time;
`ifdef WEIGHT_MASK_STATS_EN
        st_cnt_a = int'(mcnt_a); st_clean_a = int'(clean_a);
`endif
      end
      if (done_b) begin
        dcnt_b++; done_seen_b = 1'b1;
`ifdef WEIGHT_MASK_STATS_EN
        st_cnt_b = int'(mcnt_b); st_clean_b = int'(clean_b);
`endif
      end
      hold_va = ifa.out_valid && !ifa.out_ready;
      hold_da = ifa.out_data;
      hold_vb = ifb.out_valid && !ifb.out_ready;
      hold_db = ifb.out_data;
    end
  end

  // downstream ready: always 1, or a coin flip per cycle in backpressure mode
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // driver tasks
  task automatic set_bounds(input int bma, bna, mta, nta, bmb, bnb, mtb, ntb);
    base_m_a = CWA'(bma); base_n_a = CWA'(bna); m_tot_a = CWA'(mta); n_tot_a = CWA'(nta);
    base_m_b = CWB'(bmb); base_n_b = CWB'(bnb); m_tot_b = CWB'(mtb); n_tot_b = CWB'(ntb);
  endtask

  task automatic pulse_start();
    mbm_a = int'(base_m_a); mbn_a = int'(base_n_a); mmt_a = int'(m_tot_a); mnt_a = int'(n_tot_a);
    mbm_b = int'(base_m_b); mbn_b = int'(base_n_b); mmt_b = int'(m_tot_b); mnt_b = int'(n_tot_b);
    idx_a = 0; idx_b = 0; nz_a = 0; nz_b = 0; vcnt_a = 0; vcnt_b = 0; dcnt_a = 0; dcnt_b = 0;
    done_seen_a = 1'b0; done_seen_b = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mid_at >= 0 pulses start with different bounds while the tile is running
  task automatic send_words(input int n, input logic [DW-1:0] dbase, input int mid_at);
    int sent = 0, guard = 0;
    bit acc;
    while (sent < n && guard < 2000) begin
      in_valid = 1'b1;
      in_data  = dbase + DW'(sent + 1);
      if (sent == mid_at && start == 1'b0 && guard >= 0) begin
        set_bounds(0, 0, 32, 32, 0, 0, 32, 32);
        start = 1'b1;
        mid_at = -1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      acc = ifa.in_ready;
      if (ifa.in_ready) begin
        exp_qa.push_back(model(idx_a, TMA, mbm_a, mbn_a, mmt_a, mnt_a, in_data));
        idx_a++;
      end
      if (ifb.in_ready) begin
        exp_qb.push_back(model(idx_b, TMB, mbm_b, mbn_b, mmt_b, mnt_b, in_data));
        idx_b++;
      end
      if (acc && sent == 0) first_acc_t = $time;
      @(posedge clk); #1;
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("send_completed", 64'(sent), 64'(n));
  endtask

  task automatic wait_done();
    int g = 0;
    while (!(done_seen_a && done_seen_b) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("tile_done_seen", {62'd0, done_seen_a, done_seen_b}, 64'd3);
    @(posedge clk); #1;
  endtask

  task automatic end_tile(input string tag, input int nz_exp_a, input int nz_exp_b);
    @(negedge clk);
    check({tag, "_qa_empty"}, 64'(exp_qa.size()), 64'd0);
    check({tag, "_qb_empty"}, 64'(exp_qb.size()), 64'd0);
    check({tag, "_nonzero_a"}, 64'(nz_a), 64'(nz_exp_a));
    check({tag, "_nonzero_b"}, 64'(nz_b), 64'(nz_exp_b));
    check({tag, "_done_pulses_a"}, 64'(dcnt_a), 64'd1);
    check({tag, "_done_pulses_b"}, 64'(dcnt_b), 64'd1);
    check({tag, "_idle_a"}, {62'd0, busy_a, ifa.out_valid}, 64'd0);
    check({tag, "_idle_b"}, {62'd0, busy_b, ifb.out_valid}, 64'd0);
`ifdef WEIGHT_MASK_STATS_EN
    check({tag, "_masked_cnt_a"}, 64'(st_cnt_a), 64'(WORDS - nz_exp_a));
    check({tag, "_masked_cnt_b"}, 64'(st_cnt_b), 64'(WORDS - nz_exp_b));
    check({tag, "_tile_clean_a"}, 64'(st_clean_a), (nz_exp_a == WORDS) ? 64'd1 : 64'd0);
    check({tag, "_tile_clean_b"}, 64'(st_clean_b), (nz_exp_b == WORDS) ? 64'd1 : 64'd0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic run_tile(input string tag, input logic [DW-1:0] dbase, input int mid_at,
                          input int nz_exp_a, input int nz_exp_b);
    pulse_start();
    send_words(WORDS, dbase, mid_at);
    wait_done();
    end_tile(tag, nz_exp_a, nz_exp_b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {busy_a, done_a, ifa.out_valid, ifa.in_ready, dbg_a, ifa.out_data}, 64'd0);
    check({tag, "_b"}, {busy_b, done_b, ifb.out_valid, ifb.in_ready, dbg_b, ifb.out_data}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    set_bounds(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // in_valid while IDLE is not accepted
    in_valid = 1'b1; in_data = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_in_ready", {62'd0, ifa.in_ready, ifb.in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // interior tile, ramp 1..144, full throughput
    set_bounds(0, 0, 32, 32, 0, 0, 32, 32);
    pulse_start();
    send_words(WORDS, 32'd0, -1);
    wait_done();
    check("interior_done_latency", 64'(done_t_a - first_acc_t), 64'(WORDS * PERIOD));
    check("interior_valid_cycles", 64'(vcnt_a), 64'(WORDS));
    end_tile("interior", WORDS, WORDS);

    // edge tile: only tm<2, tn<1 survive -> 18 words
    set_bounds(4, 4, 6, 5, 4, 4, 6, 5);
    run_tile("edge", 32'h1000_0000, -1, 18, 18);

    // backpressure: A keeps tm<3,tn<2 (54); B keeps tm<10 (90)
    bp_mode = 1'b1;
    set_bounds(2, 1, 5, 3, 10, 0, 20, 1);
    run_tile("backpressure", 32'hBEEF_0000, -1, 54, 90);
    bp_mode = 1'b0;

    // start during RUN with wide-open bounds is ignored: A 72, B 27
    set_bounds(0, 0, 2, 4, 0, 0, 3, 1);
    run_tile("start_in_run", 32'h2000_0000, 20, 72, 27);

    // reset at word 50: outputs clear next cycle, then a full clean tile
    set_bounds(0, 0, 32, 32, 0, 0, 32, 32);
    pulse_start();
    send_words(50, 32'h3000_0000, -1);
    rst = 1'b1;
    exp_qa.delete();
    exp_qb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    run_tile("after_reset", 32'h3100_0000, -1, WORDS, WORDS);

    // overflow: base 250, total 255; B (8-bit, TM=16) keeps tm 0..4 only
    set_bounds(250, 0, 255, 255, 250, 0, 255, 255);
    run_tile("overflow", 32'h4000_0000, -1, WORDS, 45);

    // zero totals: every word masked but the whole tile is still consumed
    set_bounds(0, 0, 0, 32, 0, 0, 32, 0);
    run_tile("zero_total", 32'h5000_0000, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
